// File: rtl/dcache_miss_handler_if.sv
// ---------------------------------------------------------------------------
// dcache_miss_handler_if
// Request/response bus between the D$ miss handler and the core memory arbiter.
//   dcache_req_valid_miss  single-cycle request pulse (handler -> arbiter)
//   dcache_req_addr        line address of the request
//   dcache_req_is_store    1 = victim writeback, 0 = line-fill load
//   dcache_req_data        writeback data (0 for loads)
//   rsp_valid_miss         response valid (arbiter -> handler)
//   rsp_cache_id           0 = I$, 1 = D$
//   rsp_data_miss          response line data
//   rsp_bus_error          response carries a bus error
// Modports: master = miss handler, slave = arbiter.
// ---------------------------------------------------------------------------
interface dcache_miss_handler_if #(
    parameter int LINE_WIDTH = 128,
    parameter int ADDR_WIDTH = 32
);
    logic                  dcache_req_valid_miss;
    logic [ADDR_WIDTH-1:0] dcache_req_addr;
    logic                  dcache_req_is_store;
    logic [LINE_WIDTH-1:0] dcache_req_data;
    logic                  rsp_valid_miss;
    logic                  rsp_cache_id;
    logic [LINE_WIDTH-1:0] rsp_data_miss;
    logic                  rsp_bus_error;

    modport master (
        output dcache_req_valid_miss, dcache_req_addr, dcache_req_is_store, dcache_req_data,
        input  rsp_valid_miss, rsp_cache_id, rsp_data_miss, rsp_bus_error
    );

    modport slave (
        input  dcache_req_valid_miss, dcache_req_addr, dcache_req_is_store, dcache_req_data,
        output rsp_valid_miss, rsp_cache_id, rsp_data_miss, rsp_bus_error
    );
endinterface

// File: rtl/dcache_miss_handler.sv
// ---------------------------------------------------------------------------
// dcache_miss_handler
// Services one D$ miss at a time: optional dirty-victim writeback, then the
// line-fill load, then a single-cycle fill (or error) pulse back to the cache.
// Ports:
//   clock, reset        system clock, asynchronous active-low reset
//   miss_*, evict_*     miss request from the D$ (single-cycle, when miss_ready)
//   miss_ready          handler idle and not draining a timed-out response
//   fill_*              single-cycle completion pulse to the D$
//   bus (master)        request/response bus to the memory arbiter
//   err_spurious        sticky flag: unexpected D$ response observed
// All outputs are driven straight from flops.
// ---------------------------------------------------------------------------
module dcache_miss_handler #(
    parameter int LINE_WIDTH     = 128,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  miss_valid,
    input  logic [ADDR_WIDTH-1:0] miss_addr,
    input  logic                  miss_evict_dirty,
    input  logic [ADDR_WIDTH-1:0] evict_addr,
    input  logic [LINE_WIDTH-1:0] evict_data,
    output logic                  miss_ready,
    output logic                  fill_valid,
    output logic [ADDR_WIDTH-1:0] fill_addr,
    output logic [LINE_WIDTH-1:0] fill_data,
    output logic                  fill_error,
    dcache_miss_handler_if.master bus,
    output logic                  err_spurious
);

    // A zero timeout still needs a 1-bit counter to keep the declaration legal.
    localparam int              CNT_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit              TMO_EN    = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        WB_WAIT,
        FILL_WAIT
    } state_e;

    state_e                state_q, state_d;
    logic                  drop_pending_q, drop_pending_d;
    logic [CNT_W-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic [ADDR_WIDTH-1:0] miss_addr_q, miss_addr_d;
    logic                  miss_ready_q, miss_ready_d;
    logic                  req_valid_q, req_valid_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic                  req_is_store_q, req_is_store_d;
    logic [LINE_WIDTH-1:0] req_data_q, req_data_d;
    logic                  fill_valid_q, fill_valid_d;
    logic [ADDR_WIDTH-1:0] fill_addr_q, fill_addr_d;
    logic [LINE_WIDTH-1:0] fill_data_q, fill_data_d;
    logic                  fill_error_q, fill_error_d;
    logic                  err_spurious_q, err_spurious_d;

    logic rsp_hit;
    logic tmo_hit;

    // I$ responses share the bus and are invisible to this block.
    assign rsp_hit = bus.rsp_valid_miss && bus.rsp_cache_id;
    // A response arriving in the timeout cycle takes priority (checked first below).
    assign tmo_hit = TMO_EN && (tmo_cnt_q == TMO_LIMIT);

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case can infer a latch.
        state_d        = state_q;
        drop_pending_d = drop_pending_q;
        tmo_cnt_d      = tmo_cnt_q;
        miss_addr_d    = miss_addr_q;
        req_valid_d    = 1'b0;
        req_addr_d     = req_addr_q;
        req_is_store_d = req_is_store_q;
        req_data_d     = req_data_q;
        fill_valid_d   = 1'b0;
        fill_addr_d    = fill_addr_q;
        fill_data_d    = fill_data_q;
        fill_error_d   = 1'b0;
        err_spurious_d = err_spurious_q;

        case (state_q)
            IDLE: begin
                if (rsp_hit) begin
                    // Either the late answer to a timed-out request, or garbage.
                    if (drop_pending_q) drop_pending_d = 1'b0;
                    else                err_spurious_d = 1'b1;
                end
                if (miss_valid && miss_ready_q) begin
                    miss_addr_d = miss_addr;
                    tmo_cnt_d   = '0;
                    req_valid_d = 1'b1;
                    if (miss_evict_dirty) begin
                        state_d        = WB_WAIT;
                        req_addr_d     = evict_addr;
                        req_is_store_d = 1'b1;
                        req_data_d     = evict_data;
                    end else begin
                        state_d        = FILL_WAIT;
                        req_addr_d     = miss_addr;
                        req_is_store_d = 1'b0;
                        req_data_d     = '0;
                    end
                end
            end

            WB_WAIT: begin
                if (rsp_hit) begin
                    if (!bus.rsp_bus_error) begin
                        state_d        = FILL_WAIT;
                        tmo_cnt_d      = '0;
                        req_valid_d    = 1'b1;
                        req_addr_d     = miss_addr_q;
                        req_is_store_d = 1'b0;
                        req_data_d     = '0;
                    end else begin
                        // Failed writeback: the fill is abandoned, never issued.
                        state_d      = IDLE;
                        fill_valid_d = 1'b1;
                        fill_error_d = 1'b1;
                        fill_addr_d  = miss_addr_q;
                        fill_data_d  = '0;
                    end
                end else if (tmo_hit) begin
                    state_d        = IDLE;
                    drop_pending_d = 1'b1;
                    fill_valid_d   = 1'b1;
                    fill_error_d   = 1'b1;
                    fill_addr_d    = miss_addr_q;
                    fill_data_d    = '0;
                end else if (TMO_EN) begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
            end

            FILL_WAIT: begin
                if (rsp_hit) begin
                    state_d      = IDLE;
                    fill_valid_d = 1'b1;
                    fill_error_d = bus.rsp_bus_error;
                    fill_addr_d  = miss_addr_q;
                    fill_data_d  = bus.rsp_data_miss;
                end else if (tmo_hit) begin
                    state_d        = IDLE;
                    drop_pending_d = 1'b1;
                    fill_valid_d   = 1'b1;
                    fill_error_d   = 1'b1;
                    fill_addr_d    = miss_addr_q;
                    fill_data_d    = '0;
                end else if (TMO_EN) begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase

        // Registered ready reflects the state the handler is about to be in.
        miss_ready_d = (state_d == IDLE) && !drop_pending_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: datapath flops are reset too, because every output must read 0 while in reset.
            state_q        <= IDLE;
            drop_pending_q <= 1'b0;
            tmo_cnt_q      <= '0;
            miss_addr_q    <= '0;
            miss_ready_q   <= 1'b0;
            req_valid_q    <= 1'b0;
            req_addr_q     <= '0;
            req_is_store_q <= 1'b0;
            req_data_q     <= '0;
            fill_valid_q   <= 1'b0;
            fill_addr_q    <= '0;
            fill_data_q    <= '0;
            fill_error_q   <= 1'b0;
            err_spurious_q <= 1'b0;
        end else begin
            // NOTE: non-blocking only, so every flop updates from the same pre-edge values.
            state_q        <= state_d;
            drop_pending_q <= drop_pending_d;
            tmo_cnt_q      <= tmo_cnt_d;
            miss_addr_q    <= miss_addr_d;
            miss_ready_q   <= miss_ready_d;
            req_valid_q    <= req_valid_d;
            req_addr_q     <= req_addr_d;
            req_is_store_q <= req_is_store_d;
            req_data_q     <= req_data_d;
            fill_valid_q   <= fill_valid_d;
            fill_addr_q    <= fill_addr_d;
            fill_data_q    <= fill_data_d;
            fill_error_q   <= fill_error_d;
            err_spurious_q <= err_spurious_d;
        end
    end

    assign miss_ready              = miss_ready_q;
    assign fill_valid              = fill_valid_q;
    assign fill_addr               = fill_addr_q;
    assign fill_data               = fill_data_q;
    assign fill_error              = fill_error_q;
    assign err_spurious            = err_spurious_q;
    assign bus.dcache_req_valid_miss = req_valid_q;
    assign bus.dcache_req_addr       = req_addr_q;
    assign bus.dcache_req_is_store   = req_is_store_q;
    assign bus.dcache_req_data       = req_data_q;

endmodule
